// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch-predictor types, counter constants and helpers
package bp_pkg;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t STRONG_LOCAL  = 2'd0;
  localparam ctr2_t WEAK_LOCAL    = 2'd1;
  localparam ctr2_t WEAK_GLOBAL   = 2'd2;
  localparam ctr2_t STRONG_GLOBAL = 2'd3;

  // Widest chooser index any instance may use; narrower instances zero-fill.
  localparam int IDX_W_MAX = 16;

  typedef struct packed {
    logic [IDX_W_MAX-1:0] idx;
    logic                 global_pred;
    logic                 local_pred;
    logic                 pred;
  } fifo_entry_t;

  function automatic ctr2_t ctr_step(input ctr2_t c, input logic up);
    if (up) return (c == STRONG_GLOBAL) ? c : c + 2'd1;
    return (c == STRONG_LOCAL) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/tournament_chooser_ctrl_if.sv
// rtl/tournament_chooser_ctrl_if.sv - fetch/resolve/update bundle of the chooser controller
interface tournament_chooser_ctrl_if;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        global_pred;
  logic        local_pred;
  logic        pred_br;
  logic        resolve_valid;
  logic        resolve_br_en;
  logic        flush;
  logic        full;
  logic        empty;
  logic        upd_ld;
  logic        upd_br_en;
  logic        mispredict;

  modport master (
    output fetch_valid, fetch_pc, global_pred, local_pred,
    output resolve_valid, resolve_br_en, flush,
    input  pred_br, full, empty, upd_ld, upd_br_en, mispredict
  );

  modport slave (
    input  fetch_valid, fetch_pc, global_pred, local_pred,
    input  resolve_valid, resolve_br_en, flush,
    output pred_br, full, empty, upd_ld, upd_br_en, mispredict
  );
endinterface

// File: rtl/pred_fifo.sv
// rtl/pred_fifo.sv - in-flight prediction queue; caller gates push on !full and pop on !empty
module pred_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_flush,
  input  fifo_entry_t i_data,
  output fifo_entry_t o_head,
  output logic        o_full,
  output logic        o_empty
);
  localparam int PW = $clog2(DEPTH);

  fifo_entry_t   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/tournament_chooser_ctrl.sv
// rtl/tournament_chooser_ctrl.sv - tournament chooser table, in-flight tracking and update strobes
module tournament_chooser_ctrl
  import bp_pkg::*;
#(
  parameter int pc_idx_start = 6,
  parameter int pc_idx_width = 4,
  parameter int fifo_depth   = 4
) (
  input logic                       clk,
  input logic                       rst,
  tournament_chooser_ctrl_if.slave  bus
);
  localparam int N_ENTRIES = 2 ** pc_idx_width;

  ctr2_t                   r_chooser [N_ENTRIES];
  logic                    r_upd_ld;
  logic                    r_upd_br_en;
  logic                    r_mispredict;
  logic [pc_idx_width-1:0] w_fetch_idx;
  logic [pc_idx_width-1:0] w_head_idx;
  fifo_entry_t             w_push_entry;
  fifo_entry_t             w_head;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_unused;

  assign w_fetch_idx = bus.fetch_pc[pc_idx_start +: pc_idx_width];
  assign w_head_idx  = w_head.idx[pc_idx_width-1:0];
  assign w_unused    = ^{bus.fetch_pc, w_head.idx};

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign bus.pred_br = r_chooser[w_fetch_idx][1] ? bus.global_pred : bus.local_pred;

  assign w_push = bus.fetch_valid && !w_full && !bus.flush;
  assign w_pop  = bus.resolve_valid && !w_empty;

  always_comb begin
    w_push_entry                         = '0;
    w_push_entry.idx[pc_idx_width-1:0]   = w_fetch_idx;
    w_push_entry.global_pred             = bus.global_pred;
    w_push_entry.local_pred              = bus.local_pred;
    w_push_entry.pred                    = bus.pred_br;
  end

  pred_fifo #(.DEPTH(fifo_depth)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.flush),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRIES; i++) r_chooser[i] <= WEAK_LOCAL;
    end else if (w_pop && (w_head.global_pred != w_head.local_pred)) begin
      r_chooser[w_head_idx] <= ctr_step(r_chooser[w_head_idx],
                                        w_head.global_pred == bus.resolve_br_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_upd_ld     <= 1'b0;
      r_upd_br_en  <= 1'b0;
      r_mispredict <= 1'b0;
    end else begin
      r_upd_ld     <= w_pop;
      r_upd_br_en  <= w_pop && bus.resolve_br_en;
      r_mispredict <= w_pop && (w_head.pred != bus.resolve_br_en);
    end
  end

  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.upd_ld     = r_upd_ld;
  assign bus.upd_br_en  = r_upd_br_en;
  assign bus.mispredict = r_mispredict;
endmodule

// File: doc/tournament_chooser_ctrl.md
TOURNAMENT_CHOOSER_CTRL -- requirements
Module: tournament_chooser_ctrl

Interface
REQ-001 Parameter pc_idx_start, default 6, LSB position of the chooser index within the PC.
REQ-002 Parameter pc_idx_width, default 4, chooser index width; the chooser table holds 2**pc_idx_width entries.
REQ-003 Parameter fifo_depth, default 4, number of in-flight predictions; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 fetch_valid  input  1  a branch prediction is requested this cycle.
REQ-007 fetch_pc  input  32  PC of the fetching branch.
REQ-008 global_pred  input  1  prediction from the global predictor for fetch_pc.
REQ-009 local_pred  input  1  prediction from the local PHT for fetch_pc.
REQ-010 pred_br  output  1  final selected prediction, combinational.
REQ-011 resolve_valid  input  1  the oldest in-flight branch resolves this cycle.
REQ-012 resolve_br_en  input  1  actual outcome of the resolving branch.
REQ-013 flush  input  1  discard all in-flight predictions.
REQ-014 full  output  1  FIFO full; fetch shall stall.
REQ-015 empty  output  1  FIFO empty.
REQ-016 upd_ld  output  1  one-cycle load strobe to both predictors (their pred_ld).
REQ-017 upd_br_en  output  1  outcome presented with upd_ld (their br_en).
REQ-018 mispredict  output  1  one-cycle pulse: the resolved final prediction was wrong.

Function
REQ-019 Chooser index = fetch_pc[pc_idx_start+pc_idx_width-1 : pc_idx_start].
REQ-020 Each chooser entry is a 2-bit saturating counter; bit 1 set selects global, clear selects local.
REQ-021 pred_br = global_pred if chooser[index] bit 1 is set, else local_pred, regardless of fetch_valid.
REQ-022 Push: fetch_valid and not full stores {index, global_pred, local_pred, pred_br} at the FIFO tail.
REQ-023 fetch_valid while full is ignored; no state change.
REQ-024 Pop: resolve_valid and not empty removes the head entry.
REQ-025 resolve_valid while empty is ignored; no counter update, no upd_ld, no mispredict.
REQ-026 Simultaneous push and pop with 0 < occupancy < fifo_depth leaves occupancy unchanged; full and empty use the pre-edge occupancy.
REQ-027 On pop with head global != head local: chooser[head index] increments (saturating at 3) if global == resolve_br_en, else decrements (saturating at 0).
REQ-028 On pop with head global == head local: chooser unchanged.
REQ-029 Pop registers upd_ld=1, upd_br_en=resolve_br_en, mispredict=(head pred != resolve_br_en), valid the cycle after the pop; otherwise upd_ld=0 and mispredict=0.
REQ-030 A chooser write and a lookup of the same index in the same cycle: pred_br uses the pre-update value.
REQ-031 flush sets occupancy to 0 and takes priority over a same-cycle push; a same-cycle pop is still processed (chooser update, strobes) before clearing.
REQ-032 flush leaves chooser contents unchanged.
REQ-033 Head and tail pointers wrap modulo fifo_depth.

Reset
REQ-034 rst sets all chooser entries to 2'b01 (weakly local), occupancy 0, pointers 0.
REQ-035 During and after reset: full=0, empty=1, upd_ld=0, upd_br_en=0, mispredict=0.
REQ-036 rst asserted mid-operation discards in-flight entries and pending strobes and has priority over all other inputs.

Structure
REQ-037 Shared package bp_pkg holds the 2-bit counter typedef, the FIFO entry struct, and the counter constants STRONG_LOCAL=0, WEAK_LOCAL=1, WEAK_GLOBAL=2, STRONG_GLOBAL=3.
REQ-038 In-flight storage is a sub-module pred_fifo (synchronous push/pop/flush, full/empty flags); the chooser table and control stay in tournament_chooser_ctrl.

Verification
REQ-039 After reset, fetch_pc=0x40, global=1, local=0 -> pred_br=0; empty=1 before the push, 0 after.
REQ-040 Two pushes/resolves at index 1 with global=1, local=0, br_en=1 -> chooser[1] goes 1->2->3; the third fetch gives pred_br=1; a fourth resolve leaves the counter saturated at 3.
REQ-041 Four pushes without resolve -> full=1; a fifth fetch_valid is ignored; resolve four times -> upd_ld pulses four times in order with matching upd_br_en.
REQ-042 Push with pred_br=1 followed by resolve_br_en=0 -> mispredict=1 and upd_ld=1 exactly one cycle after the resolve.
REQ-043 Three entries, flush with simultaneous resolve -> head update applied, upd_ld pulses once, then empty=1; chooser retains its values.
REQ-044 resolve_valid on empty FIFO and fetch_valid when full with rst asserted mid-stream -> no strobes; all outputs return to reset values the cycle after rst.
